// File: rtl/limit_datapath.sv
// Counted, saturating sample accumulator that raises limit when the target count is reached.
// Optional sample-accept prescaler enabled by defining LIMIT_DP_PRESCALE_EN.
module limit_datapath #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 12,
    parameter int unsigned PRESCALE = 4
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic              sreset,
    input  logic              run,
    input  logic [7:0]        limit_val,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              limit,
    output logic [7:0]        count,
    output logic [ACC_W-1:0]  acc,
    output logic              overflow,
    output logic [ACC_W-1:0]  result
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic [CNT_W-1:0] lim_q;
    logic             tick_c;
    logic             active_c;
    logic             accept_c;
    logic             sat_c;
    logic             hit_c;
    logic [SUM_W-1:0] sum_c;
    logic [ACC_W-1:0] acc_next_c;
    logic [CNT_W-1:0] count_next_c;

    // Eligibility, saturating sum and target detection for the current edge
    always_comb begin
        active_c     = !sreset && run && !limit;
        accept_c     = active_c && (lim_q != '0) && din_valid && tick_c;
        sum_c        = SUM_W'(acc) + SUM_W'(din);
        sat_c        = sum_c[SUM_W-1];
        acc_next_c   = sat_c ? ACC_MAX : sum_c[ACC_W-1:0];
        count_next_c = count + CNT_W'(1);
        hit_c        = (count_next_c == lim_q);
    end

`ifdef LIMIT_DP_PRESCALE_EN
    localparam int unsigned PS_W = 8;
    logic [PS_W-1:0] ps_cnt;

    assign tick_c = (ps_cnt == PS_W'(PRESCALE - 1));

    // Modulo-PRESCALE counter advancing only on active run cycles
    always_ff @(posedge mclk) begin
        if (reset || sreset) begin
            ps_cnt <= '0;
        end else if (active_c) begin
            ps_cnt <= tick_c ? '0 : ps_cnt + PS_W'(1);
        end
    end
`else
    logic unused_prescale;
    assign tick_c          = 1'b1;
    assign unused_prescale = ^32'(PRESCALE);
`endif

    // Accumulator, count, flags and result; reset beats sreset beats acceptance
    always_ff @(posedge mclk) begin
        if (reset) begin
            lim_q    <= '0;
            count    <= '0;
            acc      <= '0;
            overflow <= 1'b0;
            limit    <= 1'b0;
            result   <= '0;
        end else if (sreset) begin
            lim_q    <= limit_val;
            count    <= '0;
            acc      <= '0;
            overflow <= 1'b0;
            limit    <= 1'b0;
        end else if (active_c && (lim_q == '0)) begin
            // Zero target completes immediately without consuming a sample
            limit  <= 1'b1;
            result <= acc;
        end else if (accept_c) begin
            count    <= count_next_c;
            acc      <= acc_next_c;
            overflow <= overflow | sat_c;
            if (hit_c) begin
                limit  <= 1'b1;
                result <= acc_next_c;
            end
        end
    end

endmodule

// File: tb/tb_limit_datapath.sv
// Directed self-checking bench for limit_datapath: vector table plus saturation,
// reset-abort and (when LIMIT_DP_PRESCALE_EN is defined) prescale sequences.
module tb_limit_datapath;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 12;
    localparam int unsigned NVEC   = 19;

    logic              mclk = 1'b0;
    logic              reset;
    logic              sreset;
    logic              run;
    logic [7:0]        limit_val;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              limit;
    logic [7:0]        count;
    logic [ACC_W-1:0]  acc;
    logic              overflow;
    logic [ACC_W-1:0]  result;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic             rst;
        logic             sr;
        logic             rn;
        logic [7:0]       lv;
        logic [7:0]       d;
        logic             dv;
        logic             e_lim;
        logic [7:0]       e_cnt;
        logic [ACC_W-1:0] e_acc;
        logic             e_ovf;
        logic [ACC_W-1:0] e_res;
    } vec_t;

    vec_t vecs [NVEC];

    limit_datapath #(.DATA_W(DATA_W), .ACC_W(ACC_W), .PRESCALE(4)) dut (
        .mclk      (mclk),
        .reset     (reset),
        .sreset    (sreset),
        .run       (run),
        .limit_val (limit_val),
        .din       (din),
        .din_valid (din_valid),
        .limit     (limit),
        .count     (count),
        .acc       (acc),
        .overflow  (overflow),
        .result    (result)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string name, input logic e_lim, input logic [7:0] e_cnt,
                         input logic [ACC_W-1:0] e_acc, input logic e_ovf,
                         input logic [ACC_W-1:0] e_res);
        tests++;
        if (limit !== e_lim || count !== e_cnt || acc !== e_acc ||
            overflow !== e_ovf || result !== e_res) begin
            fails++;
            $display("FAIL %s: got lim=%0b cnt=%0d acc=%0d ovf=%0b res=%0d, want lim=%0b cnt=%0d acc=%0d ovf=%0b res=%0d",
                     name, limit, count, acc, overflow, result, e_lim, e_cnt, e_acc, e_ovf, e_res);
        end
    endtask

    // Drive on the falling edge, then sample just after the next rising edge
    task automatic step(input logic rst, input logic sr, input logic rn, input logic [7:0] lv,
                        input logic [7:0] d, input logic dv);
        @(negedge mclk);
        reset = rst; sreset = sr; run = rn; limit_val = lv; din = d; din_valid = dv;
        @(posedge mclk);
        #1;
    endtask

    initial begin
        reset = 1'b1; sreset = 1'b0; run = 1'b0; limit_val = '0; din = '0; din_valid = 1'b0;

        //          rst   sr    run   lv     din    dv    lim   cnt    acc       ovf   res
        vecs[0]  = {1'b1, 1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0, 8'd0, 12'd0,  1'b0, 12'd0};
        vecs[1]  = {1'b1, 1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0, 8'd0, 12'd0,  1'b0, 12'd0};
        vecs[2]  = {1'b0, 1'b1, 1'b0, 8'd3,  8'd0,  1'b0, 1'b0, 8'd0, 12'd0,  1'b0, 12'd0};
        vecs[3]  = {1'b0, 1'b0, 1'b1, 8'd3,  8'd10, 1'b1, 1'b0, 8'd1, 12'd10, 1'b0, 12'd0};
        vecs[4]  = {1'b0, 1'b0, 1'b1, 8'd3,  8'd20, 1'b1, 1'b0, 8'd2, 12'd30, 1'b0, 12'd0};
        vecs[5]  = {1'b0, 1'b0, 1'b1, 8'd3,  8'd30, 1'b1, 1'b1, 8'd3, 12'd60, 1'b0, 12'd60};
        vecs[6]  = {1'b0, 1'b0, 1'b1, 8'd3,  8'd40, 1'b1, 1'b1, 8'd3, 12'd60, 1'b0, 12'd60};
        vecs[7]  = {1'b0, 1'b1, 1'b1, 8'd5,  8'd1,  1'b1, 1'b0, 8'd0, 12'd0,  1'b0, 12'd60};
        vecs[8]  = {1'b0, 1'b0, 1'b1, 8'd5,  8'd7,  1'b1, 1'b0, 8'd1, 12'd7,  1'b0, 12'd60};
        vecs[9]  = {1'b0, 1'b0, 1'b1, 8'd5,  8'd8,  1'b1, 1'b0, 8'd2, 12'd15, 1'b0, 12'd60};
        vecs[10] = {1'b0, 1'b0, 1'b0, 8'd5,  8'd50, 1'b1, 1'b0, 8'd2, 12'd15, 1'b0, 12'd60};
        vecs[11] = {1'b0, 1'b0, 1'b1, 8'd5,  8'd50, 1'b0, 1'b0, 8'd2, 12'd15, 1'b0, 12'd60};
        vecs[12] = {1'b0, 1'b1, 1'b1, 8'd2,  8'd9,  1'b1, 1'b0, 8'd0, 12'd0,  1'b0, 12'd60};
        vecs[13] = {1'b0, 1'b0, 1'b1, 8'd99, 8'd1,  1'b1, 1'b0, 8'd1, 12'd1,  1'b0, 12'd60};
        vecs[14] = {1'b0, 1'b0, 1'b1, 8'd99, 8'd2,  1'b1, 1'b1, 8'd2, 12'd3,  1'b0, 12'd3};
        vecs[15] = {1'b0, 1'b1, 1'b1, 8'd0,  8'd99, 1'b1, 1'b0, 8'd0, 12'd0,  1'b0, 12'd3};
        vecs[16] = {1'b0, 1'b0, 1'b1, 8'd0,  8'd99, 1'b1, 1'b1, 8'd0, 12'd0,  1'b0, 12'd0};
        vecs[17] = {1'b0, 1'b0, 1'b1, 8'd0,  8'd99, 1'b1, 1'b1, 8'd0, 12'd0,  1'b0, 12'd0};
        vecs[18] = {1'b1, 1'b0, 1'b1, 8'd0,  8'd99, 1'b1, 1'b0, 8'd0, 12'd0,  1'b0, 12'd0};

`ifndef LIMIT_DP_PRESCALE_EN
        for (int i = 0; i < int'(NVEC); i++) begin
            step(vecs[i].rst, vecs[i].sr, vecs[i].rn, vecs[i].lv, vecs[i].d, vecs[i].dv);
            check($sformatf("vec%0d", i), vecs[i].e_lim, vecs[i].e_cnt, vecs[i].e_acc,
                  vecs[i].e_ovf, vecs[i].e_res);
        end

        // Saturation: 20 samples of 255 against a 12-bit accumulator
        begin
            int          sum;
            logic        e_ovf;
            logic [11:0] e_acc;
            step(1'b0, 1'b1, 1'b0, 8'd20, 8'd0, 1'b0);
            check("sat_clear", 1'b0, 8'd0, 12'd0, 1'b0, 12'd0);
            sum = 0;
            for (int k = 1; k <= 20; k++) begin
                step(1'b0, 1'b0, 1'b1, 8'd20, 8'd255, 1'b1);
                sum   = 255 * k;
                e_ovf = (sum > 4095);
                e_acc = (sum > 4095) ? 12'd4095 : 12'(sum);
                check($sformatf("sat_s%0d", k), (k == 20), 8'(k), e_acc, e_ovf,
                      (k == 20) ? 12'd4095 : 12'd0);
            end
            step(1'b0, 1'b0, 1'b1, 8'd20, 8'd255, 1'b1);
            check("sat_frozen", 1'b1, 8'd20, 12'd4095, 1'b1, 12'd4095);
        end

        // Hard reset mid-accumulation discards the stored result too
        step(1'b0, 1'b1, 1'b0, 8'd5, 8'd0, 1'b0);
        check("abort_clear", 1'b0, 8'd0, 12'd0, 1'b0, 12'd4095);
        step(1'b0, 1'b0, 1'b1, 8'd5, 8'd4, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'd5, 8'd6, 1'b1);
        check("abort_mid", 1'b0, 8'd2, 12'd10, 1'b0, 12'd4095);
        step(1'b1, 1'b0, 1'b1, 8'd5, 8'd6, 1'b1);
        check("abort_reset", 1'b0, 8'd0, 12'd0, 1'b0, 12'd0);
        step(1'b0, 1'b0, 1'b1, 8'd5, 8'd6, 1'b1);
        check("abort_zero_target", 1'b1, 8'd0, 12'd0, 1'b0, 12'd0);
`else
        // Prescale 4: samples land on the 4th and 8th run cycles
        step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        check("ps_reset", 1'b0, 8'd0, 12'd0, 1'b0, 12'd0);
        step(1'b0, 1'b1, 1'b0, 8'd2, 8'd0, 1'b0);
        check("ps_clear", 1'b0, 8'd0, 12'd0, 1'b0, 12'd0);
        for (int c = 1; c <= 8; c++) begin
            step(1'b0, 1'b0, 1'b1, 8'd2, 8'd5, 1'b1);
            check($sformatf("ps_c%0d", c), (c == 8), 8'(c / 4), 12'(5 * (c / 4)), 1'b0,
                  (c == 8) ? 12'd10 : 12'd0);
        end
        step(1'b0, 1'b0, 1'b1, 8'd2, 8'd5, 1'b1);
        check("ps_frozen", 1'b1, 8'd2, 12'd10, 1'b0, 12'd10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/limit_datapath.md
LIMIT_DATAPATH -- requirements
Module: limit_datapath

Interface
REQ-001 Parameter DATA_W, default 8: sample width.
REQ-002 Parameter ACC_W, default 12: accumulator/result width.
REQ-003 Parameter PRESCALE, default 4: sample-accept period in cycles; used only when LIMIT_DP_PRESCALE_EN is defined; legal range 2..255.
REQ-004 mclk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high hard reset.
REQ-006 sreset  in  1  synchronous soft clear from controller; held high while controller idles or reports done.
REQ-007 run  in  1  accumulate enable from controller (high while controller in start state).
REQ-008 limit_val  in  8  target sample count; captured only while sreset=1.
REQ-009 din  in  DATA_W  unsigned sample.
REQ-010 din_valid  in  1  din qualifier.
REQ-011 limit  out  1  registered; high = target count reached; feeds controller limit input.
REQ-012 count  out  8  registered number of accepted samples.
REQ-013 acc  out  ACC_W  registered running sum.
REQ-014 overflow  out  1  registered sticky saturation flag.
REQ-015 result  out  ACC_W  registered final sum latched at limit.

Function
REQ-016 Internal lim_q shall load limit_val every cycle sreset=1; limit_val changes while sreset=0 shall have no effect.
REQ-017 A sample shall be accepted on an edge where sreset=0, run=1, limit=0, din_valid=1 and (with the macro) tick=1.
REQ-018 On acceptance: count <= count+1; acc <= min(acc+din, 2^ACC_W-1); overflow <= 1 if the unsaturated sum exceeds 2^ACC_W-1.
REQ-019 On the edge accepting the sample that makes count+1 == lim_q: limit <= 1 and result <= the new saturated acc value, same edge (limit visible one cycle after the accepting edge).
REQ-020 If lim_q == 0: on the first edge with sreset=0, run=1, limit=0: limit <= 1, result <= acc (0), no sample accepted regardless of din_valid.
REQ-021 While limit=1: count, acc, overflow, result frozen; din ignored; limit stays high until sreset or reset.
REQ-022 run=0 with sreset=0: all registers hold (pause); resuming run continues from held values.
REQ-023 sreset=1: count, acc, overflow, limit <= 0 next edge; result retained; sreset has priority over acceptance in the same cycle.
REQ-024 count never wraps: limit asserts no later than count reaching lim_q <= 255.
REQ-025 Saturation: once acc = 2^ACC_W-1, further samples still increment count, acc stays saturated.

Reset
REQ-026 reset=1 at an edge: limit=0, count=0, acc=0, overflow=0, result=0, lim_q=0, prescale counter=0; reset has priority over sreset and acceptance.
REQ-027 reset mid-accumulation shall discard the operation fully, including result.

Configuration
REQ-028 Macro LIMIT_DP_PRESCALE_EN defined: internal modulo-PRESCALE counter increments each cycle run=1, sreset=0, limit=0; tick=1 when counter == PRESCALE-1 (counter wraps to 0); counter cleared by reset/sreset; first eligible tick is the PRESCALE-th run cycle after sreset falls.
REQ-029 Macro undefined: no prescale counter, tick is constant 1, PRESCALE ignored; samples eligible every cycle.

Verification
REQ-030 reset=1 two cycles, then reset=0 -> limit=0, count=0, acc=0, overflow=0, result=0.
REQ-031 sreset with limit_val=3, then run=1, din=10,20,30 valid on consecutive cycles (macro off) -> limit=1 one cycle after third sample, count=3, result=60, overflow=0.
REQ-032 sreset with limit_val=0, run=1 with din_valid=1 din=99 -> limit=1 after first run edge, count=0, result=0.
REQ-033 limit_val=20, din=255 every cycle -> overflow=1 after 17th sample, acc=4095, limit after 20th with result=4095, count=20.
REQ-034 limit_val=5, two samples 7,8 accepted, then sreset=1 with limit_val=2 alongside din_valid=1 -> count=0, acc=0, limit=0, result unchanged; next run of 1,2 -> result=3.
REQ-035 Macro on, PRESCALE=4, limit_val=2, din_valid=1 din=5 constant -> samples accepted on 4th and 8th run cycles, limit=1 after 8th, result=10.
